array_proc_sched: RTL and testbench
===================================

// Module: array_proc_sched
// PURPOSE
//  Shares one 8-deep sample-accumulate datapath between NREQ requesters.
//  A round-robin arbiter grants one sample per cycle; the block counts DEPTH accepted samples per
//  frame and accumulates their sum. It then presents the frame sum on a valid/ready port.
//  Sits between producer channels and the downstream sum consumer.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  DATA_W  8   sample width
//  DEPTH   8   samples per frame (power of two, >=2)
//  ACC_W   8   frame-sum width; overflow handled per CONFIGURATION
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            asynchronous, active-high reset
//  en           in   1            enable frame collection
//  req          in   NREQ         per-requester sample-valid
//  req_data     in   NREQ*DATA_W  sample of requester i at [i*DATA_W +: DATA_W]
//  gnt          out  NREQ         one-hot grant; sample accepted when req[i]&gnt[i]
//  frame_sum    out  ACC_W        sum of the completed frame
//  frame_valid  out  1            frame_sum valid; held until frame_ready
//  frame_ready  in   1            consumer accepts frame
//  frame_idx    out  log2(DEPTH)  samples accepted so far in the current frame
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, frame_sum=0, frame_valid=0, frame_idx=0, acc=0, rr_ptr=0.
//  FSM IDLE -> FILL when en=1.
//   FILL: gnt is combinational, the first req at or after rr_ptr (wrapping); gnt=0 if req=0.
//     Each accept: acc+=sample, frame_idx+=1, rr_ptr <= granted+1 (mod NREQ).
//     The DEPTH-th accept -> HOLD next cycle; frame_sum<=final acc; frame_valid=1; frame_idx wraps to 0.
//   HOLD: gnt=0 (back-pressure); frame_valid stays 1 and frame_sum stays stable until frame_ready=1.
//     On handshake: acc=0; next state is FILL if en=1, else IDLE.
//  Latency: frame_valid rises 1 cycle after the DEPTH-th accepting edge.
//  At most one sample is accepted per cycle; requesters with no grant must hold req and data.
//  en=0 mid-frame: the current frame completes; en is sampled only in IDLE and on the HOLD handshake.
//  frame_ready while frame_valid=0: ignored.
//  Reset mid-frame: partial acc is discarded and no frame is emitted.
//  rr_ptr is not advanced on a cycle with no accept.
// CONFIGURATION
//  ARRAY_SCHED_SAT_EN defined: acc clamps at 2**ACC_W-1; stays there for the rest of the frame.
//  Not defined: acc wraps modulo 2**ACC_W, matching the existing datapath.
// STRUCTURE
//  Package array_proc_pkg holds:
//   - state typedef {IDLE,FILL,HOLD}
//   - default DATA_W/DEPTH constants
//   - function sat_add(acc, sample)
//  Sub-module rr_arbiter #(NREQ) (req, ptr -> one-hot gnt, gnt_idx), purely combinational.
//  All state lives in array_proc_sched.
// TESTING
//  1 Reset: rst=1 mid-FILL with idx=5 -> all outputs 0 and state IDLE next cycle; no frame_valid.
//  2 Single requester: en=1, req=4'b0001, data=1..8 -> frame_sum=36 (0x24), frame_valid 1 cycle after 8th accept.
//  3 Fairness: req=4'b1111 constant -> gnt order 0,1,2,3,0,1,2,3; each requester gets 2 grants per frame.
//  4 Back-pressure: hold frame_ready=0 for 5 cycles -> frame_valid and frame_sum stable, gnt=0.
//     Then ready=1 -> FILL resumes next cycle from rr_ptr.
//  5 Overflow: 8 samples of 0x40 -> without SAT frame_sum=0x00; with ARRAY_SCHED_SAT_EN frame_sum=0xFF.
//  6 en drop: deassert en at idx=3 -> frame completes with 8 samples, then IDLE with gnt=0.

Source files
------------

// File: rtl/array_proc_pkg.sv
// Shared types and defaults for the array sample-accumulate scheduler.
// sat_add clamps an unsigned sum at a caller-supplied ceiling.
package array_proc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } state_t;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ACC_W  = 8;

  function automatic logic [31:0] sat_add(
    input logic [31:0] acc,
    input logic [31:0] sample,
    input logic [31:0] max
  );
    logic [32:0] s;
    s = {1'b0, acc} + {1'b0, sample};
    if (s > {1'b0, max})
      sat_add = max;
    else
      sat_add = s[31:0];
  endfunction

endpackage

// File: rtl/array_proc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first
// active request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ)
        idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/array_proc_sched.sv
// Round-robin shared sample accumulator emitting DEPTH-sample frame sums.
// Define ARRAY_SCHED_SAT_EN to clamp the sum instead of wrapping.
module array_proc_sched
  import array_proc_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [ACC_W-1:0]         frame_sum,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [$clog2(DEPTH)-1:0] frame_idx
);

  localparam int PW = $clog2(NREQ);
  localparam int IW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              valid_q, valid_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic [DATA_W-1:0] sample;
  logic [ACC_W-1:0]  acc_add;
  logic              accept;
  logic              last;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

`ifdef ARRAY_SCHED_SAT_EN
  localparam logic [31:0] ACC_MAX = 32'({ACC_W{1'b1}});
  always_comb begin
    sample  = req_data[arb_idx*DATA_W +: DATA_W];
    acc_add = ACC_W'(sat_add(32'(acc_q), 32'(sample), ACC_MAX));
  end
`else
  always_comb begin
    sample  = req_data[arb_idx*DATA_W +: DATA_W];
    acc_add = acc_q + ACC_W'(sample);
  end
`endif

  // Grants only leave the block while collecting; HOLD back-pressures.
  assign gnt    = (state_q == FILL) ? arb_gnt : '0;
  assign accept = |gnt;
  assign last   = (idx_q == IW'(DEPTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (en)
          state_d = FILL;
      end
      FILL: begin
        if (accept) begin
          acc_d = acc_add;
          if (arb_idx == PW'(NREQ-1))
            ptr_d = '0;
          else
            ptr_d = arb_idx + 1'b1;
          if (last) begin
            idx_d   = '0;
            sum_d   = acc_add;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (frame_ready) begin
          valid_d = 1'b0;
          acc_d   = '0;
          state_d = en ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_sum   = sum_q;
  assign frame_valid = valid_q;
  assign frame_idx   = idx_q;

endmodule

// File: tb/tb_array_proc_sched.sv
// Directed bench for array_proc_sched: frame vectors plus
// en-drop and mid-frame reset sequences.
module tb_array_proc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  frame_sum;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  frame_idx;

  int checks = 0;
  int errors = 0;

  array_proc_sched #(
    .NREQ   (4),
    .DATA_W (8),
    .DEPTH  (8),
    .ACC_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .frame_sum   (frame_sum),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_idx   (frame_idx)
  );

  always #5 clk = ~clk;

`ifdef ARRAY_SCHED_SAT_EN
  localparam logic [7:0] SUM_V2 = 8'hFF;
  localparam logic [7:0] SUM_V5 = 8'hFF;
`else
  localparam logic [7:0] SUM_V2 = 8'h00;
  localparam logic [7:0] SUM_V5 = 8'hF8;
`endif

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    bit          inc;
    logic [15:0] order;
    logic [7:0]  sum;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Collects one frame; returns grant count, order, and latency
  // from the last grant to frame_valid.
  task automatic run_frame(input bit inc, input int drop_en_at,
                           output int n, output logic [15:0] ord,
                           output int lat, output bit timeout);
    int cyc;
    int last_cyc;
    int prev;
    int gi;
    cyc = 0;
    last_cyc = 0;
    prev = -1;
    n = 0;
    ord = '0;
    lat = -1;
    timeout = 1'b0;
    forever begin
      if (frame_valid) begin
        lat = cyc - last_cyc;
        break;
      end
      if (cyc > 60) begin
        timeout = 1'b1;
        break;
      end
      if (gnt != 4'b0) begin
        chk($sformatf("gnt_onehot@%0d", n), 32'($countones(gnt)), 32'd1);
        chk($sformatf("frame_idx@%0d", n), 32'(frame_idx), 32'(n));
        gi = 0;
        for (int j = 0; j < 4; j++)
          if (gnt[j]) gi = j;
        if (n < 8)
          ord[2*n +: 2] = 2'(gi);
        if (drop_en_at == n)
          en = 1'b0;
        prev = gi;
        n++;
        last_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
      if (inc && prev >= 0)
        req_data[prev*8 +: 8] += 8'd1;
      prev = -1;
    end
  endtask

  task automatic check_frame(input string tag, input int n,
                             input int lat, input bit timeout,
                             input logic [7:0] exp_sum);
    chk({tag, " timeout"}, 32'(timeout), 32'd0);
    chk({tag, " accepts"}, 32'(n), 32'd8);
    chk({tag, " latency"}, 32'(lat), 32'd1);
    chk({tag, " sum"}, 32'(frame_sum), 32'(exp_sum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    bit to;
    logic [15:0] ord;
    bit hit;

    vecs[0] = '{4'b1111, 32'h04030201, 1'b0, 16'hE4E4, 8'h14};
    vecs[1] = '{4'b0001, 32'h00000001, 1'b1, 16'h0000, 8'h24};
    vecs[2] = '{4'b0001, 32'h00000040, 1'b0, 16'h0000, SUM_V2};
    vecs[3] = '{4'b0101, 32'h00070005, 1'b0, 16'h2222, 8'h30};
    vecs[4] = '{4'b1010, 32'h22001100, 1'b0, 16'hDDDD, 8'hCC};
    vecs[5] = '{4'b1000, 32'hFF000000, 1'b0, 16'hFFFF, SUM_V5};

    rst = 1'b1;
    en = 1'b0;
    req = 4'b1111;
    req_data = '0;
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst sum", 32'(frame_sum), 32'd0);
    chk("rst valid", 32'(frame_valid), 32'd0);
    chk("rst idx", 32'(frame_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle gnt", 32'(gnt), 32'd0);

    req = vecs[0].req;
    req_data = vecs[0].data;
    en = 1'b1;
    for (int v = 0; v < NV; v++) begin
      run_frame(vecs[v].inc, -1, n, ord, lat, to);
      check_frame($sformatf("v%0d", v), n, lat, to, vecs[v].sum);
      chk($sformatf("v%0d order", v), 32'(ord), 32'(vecs[v].order));
      for (int c = 0; c < 5; c++) begin
        chk($sformatf("v%0d hold valid", v), 32'(frame_valid), 32'd1);
        chk($sformatf("v%0d hold sum", v), 32'(frame_sum), 32'(vecs[v].sum));
        chk($sformatf("v%0d hold gnt", v), 32'(gnt), 32'd0);
        @(negedge clk);
      end
      if (v + 1 < NV) begin
        req = vecs[v+1].req;
        req_data = vecs[v+1].data;
      end else begin
        req = 4'b0001;
        req_data = 32'h00000002;
      end
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
      chk($sformatf("v%0d release", v), 32'(frame_valid), 32'd0);
    end

    run_frame(1'b0, 3, n, ord, lat, to);
    check_frame("endrop", n, lat, to, 8'h10);
    chk("endrop en low", 32'(en), 32'd0);
    frame_ready = 1'b1;
    @(negedge clk);
    chk("endrop release", 32'(frame_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("endrop idle gnt", 32'(gnt), 32'd0);
      chk("idle ready ignored", 32'(frame_valid), 32'd0);
      chk("endrop idle idx", 32'(frame_idx), 32'd0);
    end
    frame_ready = 1'b0;

    req_data = 32'h00000003;
    en = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (frame_idx == 3'd5) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midframe reached idx5", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst gnt", 32'(gnt), 32'd0);
    chk("midrst idx", 32'(frame_idx), 32'd0);
    chk("midrst sum", 32'(frame_sum), 32'd0);
    chk("midrst valid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    chk("midrst gnt held", 32'(gnt), 32'd0);
    rst = 1'b0;
    run_frame(1'b0, -1, n, ord, lat, to);
    check_frame("postrst", n, lat, to, 8'h18);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("postrst release", 32'(frame_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
